mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl_pkg.sv | 24 ++
 rtl/mem_bus_wait_cnt.sv | 30 +++
 rtl/mem_bus_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory-bus controller: command codes, FSM states,
// wait-counter width and the region-select bit helper.
package mem_bus_ctrl_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  // Wide enough for RD_LAT (1..4) and IO_TIMEOUT (1..255) reload values
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAM_WR  = 3'd1,
    ST_RAM_RD  = 3'd2,
    ST_IO_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int unsigned region_bit(input int unsigned addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/mem_bus_wait_cnt.sv
// Loadable saturating down-counter shared by the RAM read-latency and I/O
// timeout waits.
module mem_bus_wait_cnt
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: routes one CPU load/store at a time to on-chip RAM or
// memory-mapped I/O. Optional MEM_BUS_TIMEOUT_EN adds an I/O ack timeout with sticky bus_err.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned RAM_AW     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_done,
  output logic              busy,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-2:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_rd,
  output logic              io_wr,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack
);

  localparam int unsigned REG_BIT = region_bit(ADDR_W);
  localparam int unsigned OFF_W   = ADDR_W - 1;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [OFF_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ram_write_q, ram_write_d;
  logic              io_rd_q, io_rd_d;
  logic              io_wr_q, io_wr_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

`ifdef MEM_BUS_TIMEOUT_EN
  logic              bus_err_q, bus_err_d;
`endif

  mem_bus_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .cnt_o     (cnt)
  );

  assign cnt_zero = (cnt == '0);

  // State and registered-output update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= MNONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ram_write_q <= 1'b0;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ram_write_q <= ram_write_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  // Next-state and next-output logic; strobes follow the next state so they
  // are registered yet aligned with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    bus_err_d = bus_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if ((mem_cmd == MREAD) || (mem_cmd == MWRITE)) begin
          cmd_d   = mem_cmd;
          addr_d  = mem_addr[OFF_W-1:0];
          wdata_d = write_data;
          if (mem_addr[REG_BIT]) begin
            state_d  = ST_IO_WAIT;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(IO_TIMEOUT - 1);
          end else if (mem_cmd == MWRITE) begin
            state_d = ST_RAM_WR;
          end else begin
            state_d  = ST_RAM_RD;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(RD_LAT - 1);
          end
        end
      end
      ST_RAM_WR: state_d = ST_DONE;
      ST_RAM_RD: begin
        if (cnt_zero) begin
          rdata_d = ram_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_IO_WAIT: begin
        if (io_ack) begin
          if (cmd_q == MREAD) rdata_d = io_rdata;
          state_d = ST_DONE;
`ifdef MEM_BUS_TIMEOUT_EN
        end else if (cnt_zero) begin
          bus_err_d = 1'b1;
          if (cmd_q == MREAD) rdata_d = '1;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_RAM_WR) || (state_d == ST_RAM_RD) ||
                  (state_d == ST_IO_WAIT);
    done_d      = (state_d == ST_DONE);
    ram_write_d = (state_d == ST_RAM_WR);
    io_rd_d     = (state_d == ST_IO_WAIT) && (cmd_d == MREAD);
    io_wr_d     = (state_d == ST_IO_WAIT) && (cmd_d == MWRITE);
  end

  assign read_data = rdata_q;
  assign mem_done  = done_q;
  assign busy      = busy_q;
  assign ram_addr  = addr_q[RAM_AW-1:0];
  assign ram_wdata = wdata_q;
  assign ram_write = ram_write_q;
  assign io_addr   = addr_q;
  assign io_wdata  = wdata_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;

`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl (RD_LAT=3, IO_TIMEOUT=15); the timeout
// scenario is selected by MEM_BUS_TIMEOUT_EN.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_done;
  logic        busy;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_write;
  logic [15:0] ram_rdata;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_rdata;
  logic        io_ack;

  int n_cmp;
  int n_err;

  logic [15:0] tb_mem [0:255];

  mem_bus_ctrl #(
    .DATA_W(16), .ADDR_W(9), .RAM_AW(8), .RD_LAT(3), .IO_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .mem_done(mem_done),
    .busy(busy), .bus_err(bus_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write(ram_write), .ram_rdata(ram_rdata), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr), .io_rdata(io_rdata),
    .io_ack(io_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple RAM behind the controller
  always_ff @(posedge clk) begin
    if (ram_write) tb_mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = tb_mem[ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    mem_cmd = 2'b00;
    mem_addr = '0;
    write_data = '0;
    io_rdata = '0;
    io_ack = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_read_data", 32'(read_data), 32'h0);
    check("rst_mem_done", 32'(mem_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_ram_write", 32'(ram_write), 32'h0);
    check("rst_io_rd", 32'(io_rd), 32'h0);
    check("rst_io_wr", 32'(io_wr), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    reset = 1'b0;
    tick();

    // RAM write 9'h005 <- 16'hABCD
    mem_cmd = 2'b01; mem_addr = 9'h005; write_data = 16'hABCD;
    tick();
    mem_cmd = 2'b00;
    check("wr_busy_c1", 32'(busy), 32'h1);
    check("wr_ram_write_c1", 32'(ram_write), 32'h1);
    check("wr_ram_addr", 32'(ram_addr), 32'h05);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hABCD);
    check("wr_done_c1", 32'(mem_done), 32'h0);
    tick();
    check("wr_ram_write_c2", 32'(ram_write), 32'h0);
    check("wr_done_c2", 32'(mem_done), 32'h1);
    check("wr_busy_c2", 32'(busy), 32'h0);
    tick();
    check("wr_done_c3", 32'(mem_done), 32'h0);

    // RAM read 9'h005, RD_LAT=3, with address/cmd toggled while busy
    mem_cmd = 2'b10; mem_addr = 9'h005;
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_cmd = 2'b01;
      mem_addr = 9'h1FF ^ 9'(i);
      check("rd_busy", 32'(busy), 32'h1);
      check("rd_done_early", 32'(mem_done), 32'h0);
      check("rd_ram_addr_held", 32'(ram_addr), 32'h05);
      check("rd_ram_write_none", 32'(ram_write), 32'h0);
    end
    tick();
    mem_cmd = 2'b00;
    check("rd_done", 32'(mem_done), 32'h1);
    check("rd_data", 32'(read_data), 32'hABCD);
    check("rd_busy_done", 32'(busy), 32'h0);
    tick();
    check("rd_done_off", 32'(mem_done), 32'h0);

    // Illegal command 2'b11 in IDLE is ignored
    mem_cmd = 2'b11; mem_addr = 9'h0AA; write_data = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ill_busy", 32'(busy), 32'h0);
      check("ill_ram_write", 32'(ram_write), 32'h0);
      check("ill_io", 32'({io_rd, io_wr}), 32'h0);
      check("ill_ram_addr", 32'(ram_addr), 32'h05);
    end
    mem_cmd = 2'b00;
    tick();

    // I/O read 9'h140, ack in the 5th IO_WAIT cycle
    mem_cmd = 2'b10; mem_addr = 9'h140;
    tick();
    mem_cmd = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      check("io_rd_held", 32'(io_rd), 32'h1);
      check("io_rd_addr", 32'(io_addr), 32'h40);
      check("io_rd_no_ram_write", 32'(ram_write), 32'h0);
      check("io_rd_busy", 32'(busy), 32'h1);
      check("io_rd_done_early", 32'(mem_done), 32'h0);
      if (i == 5) begin
        io_ack = 1'b1;
        io_rdata = 16'h0042;
      end
      tick();
    end
    io_ack = 1'b0;
    check("io_rd_drop", 32'(io_rd), 32'h0);
    check("io_rd_done", 32'(mem_done), 32'h1);
    check("io_rd_data", 32'(read_data), 32'h0042);
    tick();

    // I/O write 9'h1AA, ack in the entry cycle; read_data unchanged
    mem_cmd = 2'b01; mem_addr = 9'h1AA; write_data = 16'h1234;
    tick();
    mem_cmd = 2'b00;
    check("io_wr_strobe", 32'(io_wr), 32'h1);
    check("io_wr_addr", 32'(io_addr), 32'hAA);
    check("io_wr_data", 32'(io_wdata), 32'h1234);
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("io_wr_drop", 32'(io_wr), 32'h0);
    check("io_wr_done", 32'(mem_done), 32'h1);
    check("io_wr_rdata_kept", 32'(read_data), 32'h0042);
    tick();

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: timeout after 15 cycles
    mem_cmd = 2'b10; mem_addr = 9'h120;
    tick();
    mem_cmd = 2'b00;
    for (int i = 1; i <= 15; i++) begin
      check("to_io_rd", 32'(io_rd), 32'h1);
      check("to_no_err_yet", 32'(bus_err), 32'h0);
      check("to_done_early", 32'(mem_done), 32'h0);
      tick();
    end
    check("to_io_rd_drop", 32'(io_rd), 32'h0);
    check("to_done", 32'(mem_done), 32'h1);
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("to_read_data", 32'(read_data), 32'hFFFF);
    tick();
    check("to_done_once", 32'(mem_done), 32'h0);
    check("to_bus_err_sticky", 32'(bus_err), 32'h1);
`else
    // No timeout: IO_WAIT holds well past IO_TIMEOUT until ack
    mem_cmd = 2'b10; mem_addr = 9'h120;
    tick();
    mem_cmd = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      check("nto_io_rd", 32'(io_rd), 32'h1);
      check("nto_done_early", 32'(mem_done), 32'h0);
      if (i == 20) begin
        io_ack = 1'b1;
        io_rdata = 16'h7E57;
      end
      tick();
    end
    io_ack = 1'b0;
    check("nto_done", 32'(mem_done), 32'h1);
    check("nto_read_data", 32'(read_data), 32'h7E57);
    check("nto_bus_err", 32'(bus_err), 32'h0);
    tick();
`endif

    // Reset asserted mid IO_WAIT aborts asynchronously
    mem_cmd = 2'b01; mem_addr = 9'h101; write_data = 16'h5555;
    tick();
    mem_cmd = 2'b00;
    check("rstmid_io_wr_before", 32'(io_wr), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_io_wr_async", 32'(io_wr), 32'h0);
    check("rstmid_busy_async", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    io_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_done", 32'(mem_done), 32'h0);
      check("rstmid_idle", 32'({busy, io_rd, io_wr, ram_write}), 32'h0);
    end
    io_ack = 1'b0;
    check("rstmid_read_data", 32'(read_data), 32'h0);
    check("rstmid_bus_err", 32'(bus_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
